// File: rtl/ugv_pwm_pkg.sv
// Shared definitions for the UGV drive path: duty sequencer and PWM generators.
package ugv_pwm_pkg;

    localparam int PWM_RES_BITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_BRAKE = 2'd2,
        ST_DEAD  = 2'd3
    } chan_state_t;

endpackage

// File: rtl/pwm_ramp_sequencer_if.sv
// Command bus from the host decoder into the duty sequencer.
interface pwm_ramp_sequencer_if
    import ugv_pwm_pkg::*;
#(
    parameter int N = PWM_RES_BITS_DEFAULT
);
    // A command transfers on a clock edge where cmd_valid and cmd_ready are both high;
    // the master holds cmd_valid and the payload stable until that edge.
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_duty_l;
    logic [N-1:0] cmd_duty_r;
    logic         cmd_dir_l;
    logic         cmd_dir_r;

    modport master (
        output cmd_valid, cmd_duty_l, cmd_duty_r, cmd_dir_l, cmd_dir_r,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_duty_l, cmd_duty_r, cmd_dir_l, cmd_dir_r,
        output cmd_ready
    );

endinterface

// File: rtl/pwm_ramp_channel.sv
// One drive channel: target register, slewed duty, H-bridge direction and the
// IDLE/RAMP/BRAKE/DEAD sequencing between them.
module pwm_ramp_channel
    import ugv_pwm_pkg::*;
#(
    parameter int N            = PWM_RES_BITS_DEFAULT,
    parameter int RAMP_STEP    = 4,
    parameter int DEAD_PERIODS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_tick,
    input  logic        i_estop,
    input  logic [N-1:0] i_duty,
    input  logic        i_dir,
    output logic [N-1:0] o_duty,
    output logic        o_dir,
    output chan_state_t o_state,
    output chan_state_t o_state_nxt
);

    localparam logic [N:0] STEP      = (N+1)'(RAMP_STEP);
    localparam logic [3:0] DEAD_LAST = 4'(DEAD_PERIODS);

    chan_state_t  r_state;
    logic [N-1:0] r_tgt;
    logic         r_tdir;
    logic [N-1:0] r_duty;
    logic         r_dir;
    logic [3:0]   r_dcnt;

    chan_state_t  w_eval;
    chan_state_t  w_state_nxt;
    logic [N-1:0] w_tgt;
    logic         w_tdir;
    logic [N-1:0] w_dest;
    logic [N:0]   w_up;
    logic [N:0]   w_diff;
    logic [N-1:0] w_stepped;
    logic [N-1:0] w_duty_nxt;
    logic         w_dir_nxt;
    logic [3:0]   w_dcnt_nxt;
    logic [3:0]   w_dcnt_inc;
    logic [N-1:0] w_tgt_nxt;
    logic         w_tdir_nxt;

    always_comb begin
        w_tgt      = i_load ? i_duty : r_tgt;
        w_tdir     = i_load ? i_dir : r_tdir;
        w_eval     = r_state;
        w_up       = '0;
        w_diff     = '0;
        w_dest     = '0;
        w_stepped  = r_duty;
        w_state_nxt = r_state;
        w_duty_nxt = r_duty;
        w_dir_nxt  = r_dir;
        w_dcnt_nxt = r_dcnt;
        w_dcnt_inc = r_dcnt + 4'd1;
        w_tgt_nxt  = w_tgt;
        w_tdir_nxt = w_tdir;

        // A fresh command re-plans from where the channel currently is, so a
        // tick in the same cycle already steps toward the new target.
        if (i_load && (r_state != ST_DEAD)) begin
            if (w_tdir != r_dir)
                w_eval = ST_BRAKE;
            else if (r_duty == w_tgt)
                w_eval = ST_IDLE;
            else
                w_eval = ST_RAMP;
        end
        w_state_nxt = w_eval;

        w_dest = (w_eval == ST_BRAKE) ? '0 : w_tgt;
        w_up   = {1'b0, r_duty} + STEP;
        w_diff = {1'b0, r_duty} - {1'b0, w_dest};
        if (r_duty < w_dest)
            w_stepped = (w_up >= {1'b0, w_dest}) ? w_dest : w_up[N-1:0];
        else
            w_stepped = (w_diff <= STEP) ? w_dest : (r_duty - STEP[N-1:0]);

        if (i_tick) begin
            case (w_eval)
                ST_RAMP: begin
                    w_duty_nxt = w_stepped;
                    if (w_stepped == w_tgt)
                        w_state_nxt = ST_IDLE;
                end
                ST_BRAKE: begin
                    if (r_duty == '0) begin
                        w_state_nxt = ST_DEAD;
                        w_dcnt_nxt  = '0;
                    end else begin
                        w_duty_nxt = w_stepped;
                    end
                end
                ST_DEAD: begin
                    w_dcnt_nxt = w_dcnt_inc;
                    if (w_dcnt_inc == DEAD_LAST) begin
                        w_dir_nxt   = w_tdir;
                        w_state_nxt = (w_tgt == '0) ? ST_IDLE : ST_RAMP;
                    end
                end
                default: ;
            endcase
        end

        // Emergency stop kills drive but leaves the bridge direction alone.
        if (i_estop) begin
            w_state_nxt = ST_IDLE;
            w_duty_nxt  = '0;
            w_dcnt_nxt  = '0;
            w_tgt_nxt   = '0;
            w_tdir_nxt  = r_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_tgt   <= '0;
            r_tdir  <= 1'b0;
            r_duty  <= '0;
            r_dir   <= 1'b0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_tdir  <= w_tdir_nxt;
            r_duty  <= w_duty_nxt;
            r_dir   <= w_dir_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    assign o_duty      = r_duty;
    assign o_dir       = r_dir;
    assign o_state     = r_state;
    assign o_state_nxt = w_state_nxt;

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Dual-channel duty sequencer: period counter, command handshake and busy
// aggregation around two ramp channels.
module pwm_ramp_sequencer
    import ugv_pwm_pkg::*;
#(
    parameter int PWM_RESOLUTION_BITS = PWM_RES_BITS_DEFAULT,
    parameter int RAMP_STEP           = 4,
    parameter int DEAD_PERIODS        = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    pwm_ramp_sequencer_if.slave            cmd,
    input  logic                           estop,
    output logic [PWM_RESOLUTION_BITS-1:0] duty_l_o,
    output logic [PWM_RESOLUTION_BITS-1:0] duty_r_o,
    output logic                           dir_l_o,
    output logic                           dir_r_o,
    output logic                           period_tick_o,
    output logic                           busy_o,
    output chan_state_t                    dbg_state_l_o,
    output chan_state_t                    dbg_state_r_o
);

    localparam int N = PWM_RESOLUTION_BITS;

    logic [N-1:0] r_cnt;
    logic         r_busy;
    logic         w_tick;
    logic         w_dead_any;
    logic         w_load;
    chan_state_t  w_state_l;
    chan_state_t  w_state_r;
    chan_state_t  w_nxt_l;
    chan_state_t  w_nxt_r;

    // Shares clock and reset with the PWM generators, so counter 0 here is
    // the start of their period and duty updates land on period boundaries.
    always_ff @(posedge clk) begin
        if (!reset)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign w_tick        = reset & (r_cnt == '1);
    assign period_tick_o = w_tick;

    assign w_dead_any    = (w_state_l == ST_DEAD) || (w_state_r == ST_DEAD);
    assign cmd.cmd_ready = reset & ~estop & ~w_dead_any;
    assign w_load        = cmd.cmd_valid & cmd.cmd_ready;

    pwm_ramp_channel #(
        .N(N), .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)
    ) u_chan_l (
        .clk(clk), .reset(reset), .i_load(w_load), .i_tick(w_tick), .i_estop(estop),
        .i_duty(cmd.cmd_duty_l), .i_dir(cmd.cmd_dir_l),
        .o_duty(duty_l_o), .o_dir(dir_l_o), .o_state(w_state_l), .o_state_nxt(w_nxt_l)
    );

    pwm_ramp_channel #(
        .N(N), .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)
    ) u_chan_r (
        .clk(clk), .reset(reset), .i_load(w_load), .i_tick(w_tick), .i_estop(estop),
        .i_duty(cmd.cmd_duty_r), .i_dir(cmd.cmd_dir_r),
        .o_duty(duty_r_o), .o_dir(dir_r_o), .o_state(w_state_r), .o_state_nxt(w_nxt_r)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            r_busy <= 1'b0;
        else
            r_busy <= (w_nxt_l != ST_IDLE) || (w_nxt_r != ST_IDLE);
    end

    assign busy_o        = r_busy;
    assign dbg_state_l_o = w_state_l;
    assign dbg_state_r_o = w_state_r;

endmodule

// File: doc/pwm_ramp_sequencer.md
# pwm_ramp_sequencer

Dual-channel duty sequencer for the UGV drive path. It sits between the command source (host/UART decoder) and the two motor PWM generators. It accepts left/right target duty and direction commands over a valid/ready handshake. It slews each channel's duty toward its target by a fixed step once per PWM period, and enforces ramp-down plus dead time on any direction reversal, so the H-bridges never see abrupt duty or direction changes.

## Interface
- `PWM_RESOLUTION_BITS`, 8: width N of duty values; PWM period is 2^N clocks.
- `RAMP_STEP`, 4: maximum duty change per period; range 1..2^N-1.
- `DEAD_PERIODS`, 2: whole periods held at duty 0 before a direction flip; range 1..15.

Ports:
- `clk`  in  1  system clock; same clock as the PWM generators.
- `reset`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when valid & ready.
- `cmd_duty_l`, `cmd_duty_r`  in  N  target duty per channel.
- `cmd_dir_l`, `cmd_dir_r`  in  1  target direction per channel (0 = fwd).
- `estop`  in  1  synchronous emergency stop, level-sensitive.
- `duty_l_o`, `duty_r_o`  out  N  registered duty to the PWM generators.
- `dir_l_o`, `dir_r_o`  out  1  registered H-bridge direction.
- `period_tick_o`  out  1  one-cycle pulse when the period counter equals 2^N-1.
- `busy_o`  out  1  either channel is not in IDLE.

## Operation
- Free-running N-bit period counter, cleared by reset. It stays aligned with the generators' counters because they share clock and reset.
- Per-channel FSM states:
  - IDLE: duty == target and dir == target dir.
  - RAMP: dir matches, duty != target.
  - BRAKE: dir differs, ramp toward 0.
  - DEAD: duty 0, counting periods.
- On command accept, each channel re-evaluates from its current duty/dir and target:
  - IDLE, RAMP or BRAKE with matching target dir → RAMP, or IDLE if already equal.
  - Differing dir → BRAKE.
- On each tick:
  - RAMP up: duty = min(duty+STEP, target), computed at N+1 bits; never wraps.
  - RAMP down: duty = target if (duty−target) ≤ STEP, else duty−STEP.
  - BRAKE: same down-step toward 0. On the tick where duty is already 0 → DEAD, dead counter = 0.
  - DEAD: counter increments each tick. When it reaches DEAD_PERIODS, dir_o flips to target dir and the state goes to RAMP (or IDLE if target duty is 0).
  - Reaching target in RAMP → IDLE.
- Targets are single-entry per channel; a later command overwrites an earlier one (latest wins).
- cmd_ready = reset & ~estop & no channel in DEAD. Commands are refused during dead time.
- estop high:
  - next edge: duty_l_o = duty_r_o = 0, targets cleared to 0, both FSMs IDLE.
  - dir_o held.
  - Counter keeps running.
  - Releasing estop leaves duty at 0 until a new command arrives.

## Timing
- Reset values: duty_*_o = 0, dir_*_o = 0, targets 0, FSMs IDLE, busy_o = 0, period_tick_o = 0, cmd_ready = 0 while reset low.
- Reset mid-ramp: all of the above take effect on the first edge with reset low.
- Duty and dir update only on the edge where period_tick_o is high. The new values are visible from counter = 0, so duty never changes mid-period.
- Latency: the first duty change occurs at the first tick edge after acceptance, including a tick in the same cycle as acceptance. A command accepted on a tick cycle is stepped with the new target on that edge.
- Direction flip is separated from the last nonzero duty by ≥ DEAD_PERIODS+1 full periods at duty 0.
- estop and cmd_valid in the same cycle: estop wins; the command is not accepted.
- busy_o is registered and is derived from next-state.

## Structure
- Shared package `ugv_pwm_pkg`:
  - channel state enum (IDLE, RAMP, BRAKE, DEAD);
  - default resolution constant, also consumed by the PWM generators.
- Sub-module `pwm_ramp_channel`, instantiated twice. It holds the target, duty, dir, FSM and dead counter, and takes load, tick and estop strobes.
- The top holds the period counter, handshake and busy aggregation.

## Test plan
- Reset, then cmd 20/fwd on both channels: duty 4, 8, 12, 16, 20 on five consecutive ticks (every 256 clocks); busy_o drops after the fifth tick.
- From duty 0, target 10: duty 4, 8, 10; no overshoot. From 252, target 255: duty 255, no wrap. From 10, target 7: duty 7.
- Left at 8/fwd, cmd 8/rev:
  - ticks give 4, then 0;
  - two more ticks at 0 in DEAD, cmd_ready low throughout;
  - dir_l_o flips to 1, then 4, 8;
  - right channel unaffected.
- estop asserted mid-ramp at duty 12: next edge duty 0, cmd_ready 0. After release, duty stays 0 and a cmd 8 ramps 4, 8.
- Command accepted on the same cycle as period_tick_o: that edge steps toward the new target. A second command before the next tick overwrites the first.
- Reset asserted mid-reversal (DEAD): all outputs 0 next edge; cmd_ready high one cycle after release.
